// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   fetch_state_t : fetch controller state encoding
//   INSTR_W       : instruction word width
//   PC_INC        : sequential PC increment
//   NOP_INSTR     : instruction buffer contents after reset
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_W   = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller.
// Produces the next-PC value for an external PC register (loaded every
// edge), issues at most one instruction-memory request at a time, buffers
// the returned word and presents it to decode with its PC and PC+4.
// Redirects from downstream squash wrong-path requests and buffered words.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc_in / pc_next     PC register output / PC register input
//   redirect_valid/target  taken branch/jump and its target
//   imem_req_*          request channel (valid/ready, address)
//   imem_rsp_*          response channel (valid, instruction word)
//   id_valid/id_ready   handshake to decode
//   id_instr/pc/pc4     buffered instruction, its address, address+4
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_in,
  output logic [31:0]        pc_next,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               imem_req_valid,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4
);

  fetch_state_t state, state_next;
  logic         load;
  logic         handoff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    load           = 1'b0;
    handoff        = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req_valid = !redirect_valid;
        if (imem_req_valid && imem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        // A response arriving with a redirect closes the transaction, so
        // there is nothing left to drain.
        if (redirect_valid)      state_next = imem_rsp_valid ? FETCH : DRAIN;
        else if (imem_rsp_valid) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        id_valid = !redirect_valid;
        if (redirect_valid) state_next = FETCH;
        else if (id_ready) begin
          handoff    = 1'b1;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (rst) begin
      imem_req_valid = 1'b0;
      id_valid       = 1'b0;
    end
  end

  // The PC only moves on handoff or redirect, so pc_in always names the
  // instruction that is in flight or buffered.
  always_comb begin
    if (rst)                 pc_next = RESET_PC;
    else if (redirect_valid) pc_next = {redirect_target[31:2], 2'b00};
    else if (handoff)        pc_next = pc_in + PC_INC;
    else                     pc_next = pc_in;
  end

  assign imem_req_addr = pc_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_pc4   <= PC_INC;
    end else if (load) begin
      id_instr <= imem_rsp_data;
      id_pc    <= pc_in;
      id_pc4   <= pc_in + PC_INC;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: external PC register, a small
// instruction memory with programmable latency, and a scoreboard of
// expected decode handoffs pushed at request acceptance.
module tb_fetch_ctrl;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc4          (id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register outside the controller
  initial pc_in = 32'h0;
  always @(posedge clk) pc_in <= pc_next;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_handoffs = 0;

  bit          ctl_rst, ctl_ready, ctl_id_ready, ctl_redir, ctl_spur;
  logic [31:0] ctl_target;
  int unsigned ctl_lat;

  bit          mem_pending;
  logic [31:0] mem_addr;
  int unsigned mem_cnt;
  bit          last_acc, last_rsp;
  logic [31:0] last_addr;
  int unsigned last_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'hA5A5_5A5A);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [31:0] exp_pc;
    bit          hs;
    exp_t        e;
    @(posedge clk);
    if (rst) begin
      mem_pending = 1'b0;
    end else begin
      if (last_rsp)                          mem_pending = 1'b0;
      else if (mem_pending && mem_cnt != 0)  mem_cnt--;
      if (last_acc) begin
        mem_pending = 1'b1;
        mem_addr    = last_addr;
        mem_cnt     = last_lat - 1;
      end
    end
    @(negedge clk);
    rst             = ctl_rst;
    imem_req_ready  = ctl_ready;
    id_ready        = ctl_id_ready;
    redirect_valid  = ctl_redir;
    redirect_target = ctl_target;
    last_rsp        = 1'b0;
    if (!ctl_rst && mem_pending && mem_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
      last_rsp       = 1'b1;
    end else if (ctl_spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    hs = id_valid && id_ready;
    if (ctl_rst)        exp_pc = 32'h0;
    else if (ctl_redir) exp_pc = {ctl_target[31:2], 2'b00};
    else if (hs)        exp_pc = pc_in + 32'd4;
    else                exp_pc = pc_in;
    check_eq("pc_next", pc_next, exp_pc);
    if (ctl_redir || ctl_rst) begin
      sbq.delete();
      check_eq("req_valid_gated", {31'b0, imem_req_valid}, 32'h0);
      check_eq("id_valid_gated", {31'b0, id_valid}, 32'h0);
    end
    last_acc  = imem_req_valid && imem_req_ready;
    last_addr = imem_req_addr;
    last_lat  = ctl_lat;
    if (last_acc) begin
      check_eq("single_outstanding", {31'b0, mem_pending}, 32'h0);
      sbq.push_back('{instr: mem_word(imem_req_addr), pc: imem_req_addr,
                      pc4: imem_req_addr + 32'd4});
    end
    if (hs) begin
      n_handoffs++;
      check_eq("sb_depth", sbq.size(), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check_eq("sb_instr", id_instr, e.instr);
        check_eq("sb_pc", id_pc, e.pc);
        check_eq("sb_pc4", id_pc4, e.pc4);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    id_ready = 1'b0;
    ctl_rst = 1'b1; ctl_ready = 1'b1; ctl_id_ready = 1'b1; ctl_redir = 1'b0;
    ctl_spur = 1'b0; ctl_target = 32'h0; ctl_lat = 1;
    mem_pending = 1'b0; mem_addr = 32'h0; mem_cnt = 0;
    last_acc = 1'b0; last_rsp = 1'b0; last_addr = 32'h0; last_lat = 1;

    cycle(); cycle();
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_eq("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check_eq("rst_id_instr", id_instr, 32'h0);
    check_eq("rst_id_pc", id_pc, 32'h0);
    check_eq("rst_id_pc4", id_pc4, 32'h4);

    // zero-wait fetch from address 0
    ctl_rst = 1'b0;
    cycle();
    check_eq("c0_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check_eq("c0_req_addr", imem_req_addr, 32'h0);
    cycle();
    check_eq("c1_id_valid", {31'b0, id_valid}, 32'h0);
    cycle();
    check_eq("c2_id_valid", {31'b0, id_valid}, 32'h1);
    check_eq("c2_id_instr", id_instr, 32'h2008_0005);
    check_eq("c2_id_pc", id_pc, 32'h0);
    check_eq("c2_id_pc4", id_pc4, 32'h4);

    // memory not ready for 4 cycles
    ctl_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("stall_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check_eq("stall_req_addr", imem_req_addr, 32'h4);
      check_eq("stall_pc_next", pc_next, 32'h4);
    end

    // decode stall for 5 cycles in HOLD, with a spurious response
    ctl_ready = 1'b1; ctl_id_ready = 1'b0;
    cycle();
    check_eq("acc4_req_valid", {31'b0, imem_req_valid}, 32'h1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      ctl_spur = (i == 2);
      cycle();
      check_eq("dstall_id_valid", {31'b0, id_valid}, 32'h1);
      check_eq("dstall_id_instr", id_instr, mem_word(32'h4));
      check_eq("dstall_id_pc", id_pc, 32'h4);
      check_eq("dstall_id_pc4", id_pc4, 32'h8);
      check_eq("dstall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check_eq("dstall_pc_next", pc_next, 32'h4);
    end
    ctl_spur = 1'b0; ctl_id_ready = 1'b1;
    cycle();
    check_eq("dstall_release_pc_next", pc_next, 32'h8);

    // redirect in WAIT with a slow memory
    ctl_lat = 3;
    cycle();
    check_eq("w_req_addr", imem_req_addr, 32'h8);
    ctl_redir = 1'b1; ctl_target = 32'h0000_0043;
    cycle();
    check_eq("w_redir_pc_next", pc_next, 32'h40);
    ctl_redir = 1'b0;
    cycle();
    check_eq("drain_pc_in", pc_in, 32'h40);
    check_eq("drain_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_eq("drain_id_valid", {31'b0, id_valid}, 32'h0);
    cycle();
    check_eq("drain_rsp_id_valid", {31'b0, id_valid}, 32'h0);
    ctl_lat = 1;
    cycle();
    check_eq("post_drain_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check_eq("post_drain_req_addr", imem_req_addr, 32'h40);

    // redirect in HOLD with decode ready
    cycle();
    ctl_redir = 1'b1; ctl_target = 32'h100;
    cycle();
    check_eq("h_redir_pc_next", pc_next, 32'h100);
    ctl_redir = 1'b0;
    cycle();
    check_eq("h_redir_req_addr", imem_req_addr, 32'h100);
    check_eq("h_redir_req_valid", {31'b0, imem_req_valid}, 32'h1);

    // redirect coinciding with the response: no drain needed
    ctl_redir = 1'b1; ctl_target = 32'h200;
    cycle();
    ctl_redir = 1'b0;
    cycle();
    check_eq("rr_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check_eq("rr_req_addr", imem_req_addr, 32'h200);
    cycle();
    cycle();
    check_eq("rr_id_pc", id_pc, 32'h200);

    // wrap-around at the top of the address space
    ctl_redir = 1'b1; ctl_target = 32'hFFFF_FFFF;
    cycle();
    ctl_redir = 1'b0;
    cycle();
    check_eq("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle();
    cycle();
    check_eq("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    check_eq("wrap_id_pc4", id_pc4, 32'h0);
    check_eq("wrap_pc_next", pc_next, 32'h0);

    // reset asserted mid-WAIT
    ctl_lat = 3;
    cycle();
    check_eq("pre_rst_req_addr", imem_req_addr, 32'h0);
    ctl_rst = 1'b1;
    cycle();
    check_eq("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_eq("midrst_id_instr", id_instr, 32'h0);
    check_eq("midrst_id_pc", id_pc, 32'h0);
    check_eq("midrst_id_pc4", id_pc4, 32'h4);
    ctl_rst = 1'b0; ctl_lat = 1;
    cycle();
    check_eq("postrst_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check_eq("postrst_req_addr", imem_req_addr, 32'h0);
    cycle();
    cycle();
    check_eq("postrst_id_instr", id_instr, 32'h2008_0005);

    check_eq("handoff_count", n_handoffs, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
